// File: rtl/pipe_pkg.sv
// Shared fetch-side types and constants for the instruction pipeline.
package pipe_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} fetch_state_t;
  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/imem_fetch_sequencer.sv
// Boot-loads instruction memory, then owns the PC and the IF/ID slot.
module imem_fetch_sequencer
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [31:0] fetch_addr,
  input  logic [31:0] mem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        done,
  output logic        err
);
  localparam logic [31:0] MEM_TOP = 32'(MEM_BYTES);
  localparam logic [31:0] LAST_W  = 32'(MEM_BYTES - WORD_BYTES);
  localparam logic [31:0] PC0     = 32'(RESET_PC);
  localparam logic [31:0] STEP    = 32'(WORD_BYTES);

  fetch_state_t state;
  logic [31:0]  pc, waddr, pc_inc;
  logic         accept, tgt_bad;

  // Load-path strobes are combinational so a word lands the cycle it is offered.
  assign load_ready = (state == LOAD);
  assign accept     = load_ready && load_valid;
  assign mem_we     = accept;
  assign mem_waddr  = waddr;
  assign mem_wdata  = load_data;
  assign fetch_addr = pc;
  assign pc_inc     = pc + STEP;
  assign tgt_bad    = (branch_target[1:0] != 2'b00) || (branch_target >= MEM_TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= PC0;
      waddr    <= '0;
      if_valid <= 1'b0;
      if_instr <= NOP;
      if_pc    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          waddr <= '0;
        end
        LOAD: if (accept) begin
          waddr <= waddr + STEP;
          if (load_last) begin
            state <= RUN;
            pc    <= PC0;
          end else if (waddr == LAST_W) begin
            state <= HALT;
            err   <= 1'b1;
          end
        end
        RUN: begin
          // Redirect beats stall; the slot is squashed for one bubble.
          if (branch_taken) begin
            pc       <= branch_target;
            if_valid <= 1'b0;
            if (tgt_bad) begin
              state <= HALT;
              err   <= 1'b1;
            end
          end else if (!stall) begin
            if_instr <= mem_rdata;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= pc_inc;
            if (pc_inc == MEM_TOP) begin
              state <= HALT;
              done  <= 1'b1;
            end
          end
        end
        default: if_valid <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed, table-driven check of load, fetch, stall, redirect and halt paths.
module tb_imem_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_ready, mem_we;
  logic [31:0] mem_waddr, mem_wdata, fetch_addr, mem_rdata;
  logic        stall = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        if_valid, done, err;
  logic [31:0] if_instr, if_pc;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem [64];

  imem_fetch_sequencer #(.MEM_BYTES(256), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .fetch_addr(fetch_addr), .mem_rdata(mem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_waddr[7:2]] <= mem_wdata;
  assign mem_rdata = mem[fetch_addr[7:2]];

  typedef struct {
    logic        st;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] fa;
    logic        iv;
    logic [31:0] pc;
    logic        dn;
    logic        er;
  } vec_t;

  localparam logic [31:0] PBASE = 32'hC0DE_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return (a < 32'd48) ? PBASE + (a >> 2) : 32'h0;
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_load(input int n, input int last, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; load_valid = 1'b1; load_data = base + 32'(i);
      load_last = (i == last);
      #1;
      chk("ld_ready", {31'b0, load_ready}, 32'd1);
      chk("ld_we", {31'b0, mem_we}, 32'd1);
      chk("ld_waddr", mem_waddr, 32'(4 * i));
      chk("ld_wdata", mem_wdata, base + 32'(i));
      @(posedge clk); #1;
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clk);
    start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    stall = v.st; branch_taken = v.br; branch_target = v.tgt;
    #1;
    chk({tag, "_fa"}, fetch_addr, v.fa);
    chk({tag, "_we"}, {31'b0, mem_we}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_iv"}, {31'b0, if_valid}, {31'b0, v.iv});
    if (v.iv) begin
      chk({tag, "_pc"}, if_pc, v.pc);
      chk({tag, "_instr"}, if_instr, exp_word(v.pc));
    end
    chk({tag, "_done"}, {31'b0, done}, {31'b0, v.dn});
    chk({tag, "_err"}, {31'b0, err}, {31'b0, v.er});
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; load_valid = 1'b0; load_last = 1'b0; start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  vec_t tbl [24];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    //             st    br    tgt    fa     iv    pc     dn    er
    tbl[0]  = '{1'b0, 1'b0, 32'd0,   32'd0,   1'b1, 32'd0,   1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'd0,   32'd4,   1'b1, 32'd4,   1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'd0,   32'd8,   1'b1, 32'd8,   1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'd0,   32'd12,  1'b1, 32'd12,  1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'd0,   32'd16,  1'b1, 32'd12,  1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'd0,   32'd16,  1'b1, 32'd12,  1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 32'd0,   32'd16,  1'b1, 32'd12,  1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'd0,   32'd16,  1'b1, 32'd16,  1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'd0,   32'd20,  1'b1, 32'd20,  1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'd0,   32'd24,  1'b1, 32'd24,  1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'd0,   32'd28,  1'b1, 32'd28,  1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 32'd0,   32'd32,  1'b1, 32'd32,  1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 32'd0,   32'd36,  1'b1, 32'd36,  1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 32'd12,  32'd40,  1'b0, 32'd0,   1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 32'd0,   32'd12,  1'b1, 32'd12,  1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 32'd44,  32'd16,  1'b0, 32'd0,   1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 32'd0,   32'd44,  1'b1, 32'd44,  1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 32'd0,   32'd48,  1'b1, 32'd48,  1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 32'd240, 32'd52,  1'b0, 32'd0,   1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 32'd0,   32'd240, 1'b1, 32'd240, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 32'd0,   32'd244, 1'b1, 32'd244, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 32'd0,   32'd248, 1'b1, 32'd248, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 1'b0, 32'd0,   32'd252, 1'b1, 32'd252, 1'b1, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 32'd0,   32'd256, 1'b0, 32'd0,   1'b1, 1'b0};

    // Reset state
    #2;
    chk("rst_ready", {31'b0, load_ready}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_fa", fetch_addr, 32'd0);
    chk("rst_iv", {31'b0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Load 12-word program and walk through fetch/stall/redirect/end
    pulse_start();
    do_load(12, 11, PBASE);
    for (int i = 0; i < 24; i++) run_vec($sformatf("run%0d", i), tbl[i]);
    @(negedge clk); start = 1'b1; #1;
    chk("halt_ready", {31'b0, load_ready}, 32'd0);
    @(posedge clk); #1;
    chk("halt_stay_ready", {31'b0, load_ready}, 32'd0);
    chk("halt_done", {31'b0, done}, 32'd1);

    // Mid-run reset, then reload
    do_reset();
    pulse_start();
    do_load(2, 1, PBASE);
    run_vec("mr0", tbl[0]);
    run_vec("mr1", tbl[1]);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("mr_fa", fetch_addr, 32'd0);
    chk("mr_iv", {31'b0, if_valid}, 32'd0);
    chk("mr_pc", if_pc, 32'd0);
    chk("mr_instr", if_instr, 32'd0);
    chk("mr_ready", {31'b0, load_ready}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    pulse_start();
    @(negedge clk); start = 1'b0; load_valid = 1'b1; load_data = PBASE; #1;
    // Reset during an offered load word drops the write immediately
    rst_n = 1'b0; #1;
    chk("mr_ld_we", {31'b0, mem_we}, 32'd0);
    chk("mr_ld_ready", {31'b0, load_ready}, 32'd0);
    load_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Misaligned branch target halts with err
    pulse_start();
    do_load(1, 0, PBASE);
    run_vec("bt0", tbl[0]);
    run_vec("bad_tgt", '{1'b0, 1'b1, 32'h6, 32'd4, 1'b0, 32'd0, 1'b0, 1'b1});
    run_vec("bad_hold", '{1'b0, 1'b0, 32'h0, 32'h6, 1'b0, 32'd0, 1'b0, 1'b1});

    // 64 words without last: write at 252 then halt with err
    do_reset();
    pulse_start();
    do_load(64, -1, 32'hDEAD_0000);
    chk("ovf_err", {31'b0, err}, 32'd1);
    chk("ovf_ready", {31'b0, load_ready}, 32'd0);
    chk("ovf_done", {31'b0, done}, 32'd0);
    @(negedge clk); load_valid = 1'b0;
    @(posedge clk); #1;
    chk("ovf_sticky", {31'b0, err}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
